// File: rtl/pio_poll_master.sv
// Periodic Avalon-MM poller for a read-only PIO slave at word address 0.
// Reports each captured sample with valid/changed strobes and an overrun count.
module pio_poll_master #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 2,
    parameter int PERIOD       = 1000,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    output logic              sample_changed,
    output logic [7:0]        overrun_count
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, CAP} state_t;

    localparam logic [15:0] RELOAD   = 16'(PERIOD - 1);
    localparam logic [1:0]  LAT_INIT = 2'(READ_LATENCY - 1);

    state_t      state;
    state_t      state_nx;
    logic [15:0] cnt;
    logic [1:0]  lat;
    logic        first_flag;
    logic        chg_q;
    logic        tick;
    logic        accept;
    logic        capture;
    logic        unused_readdata;

    assign tick            = enable && (cnt == '0);
    assign avm_address     = '0;
    assign sample_changed  = sample_valid && chg_q;
    assign unused_readdata = ^avm_readdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= RELOAD;
        end else if (!enable || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end

    always_comb begin
        state_nx     = state;
        avm_read     = 1'b0;
        sample_valid = 1'b0;
        accept       = 1'b0;
        capture      = 1'b0;
        unique case (state)
            IDLE: if (tick) state_nx = REQ;
            REQ: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    accept   = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: if (lat == '0) begin
                capture  = 1'b1;
                state_nx = CAP;
            end
            CAP: begin
                sample_valid = 1'b1;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Change flag is resolved at the capture edge, against the still-old sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            lat           <= '0;
            sample_data   <= '0;
            chg_q         <= 1'b0;
            first_flag    <= 1'b1;
            overrun_count <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lat <= LAT_INIT;
            end else if (state == WAIT && lat != '0) begin
                lat <= lat - 2'd1;
            end
            if (capture) begin
                sample_data <= avm_readdata[DATA_W-1:0];
                chg_q <= first_flag ||
                         (avm_readdata[DATA_W-1:0] != sample_data);
            end
            if (state == CAP) first_flag <= 1'b0;
            if (tick && state != IDLE && overrun_count != 8'hFF) begin
                overrun_count <= overrun_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pio_poll_master.sv
// Bench for pio_poll_master: two instances (read latency 1 and 3) share stimulus;
// a timestamp model predicts outputs each cycle, literal checks pin key points.
module tb_pio_poll_master;

    localparam int DW = 16;
    localparam int P  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        wr;
    logic [31:0] rdat;

    logic [1:0]    adr [2];
    logic          rdq [2];
    logic [DW-1:0] sd  [2];
    logic          sv  [2];
    logic          sc  [2];
    logic [7:0]    ov  [2];

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    pio_poll_master #(
        .DATA_W(DW), .ADDR_W(2), .PERIOD(P), .READ_LATENCY(1)
    ) d0 (
        .clk(clk), .reset(reset), .enable(en),
        .avm_address(adr[0]), .avm_read(rdq[0]),
        .avm_waitrequest(wr), .avm_readdata(rdat),
        .sample_data(sd[0]), .sample_valid(sv[0]),
        .sample_changed(sc[0]), .overrun_count(ov[0])
    );

    pio_poll_master #(
        .DATA_W(DW), .ADDR_W(2), .PERIOD(P), .READ_LATENCY(3)
    ) d1 (
        .clk(clk), .reset(reset), .enable(en),
        .avm_address(adr[1]), .avm_read(rdq[1]),
        .avm_waitrequest(wr), .avm_readdata(rdat),
        .sample_data(sd[1]), .sample_valid(sv[1]),
        .sample_changed(sc[1]), .overrun_count(ov[1])
    );

    // Model: cycle timestamps for acceptance, capture and strobe.
    int            cyc     = 0;
    int            m_since = 0;
    bit            m_req   [2] = '{0, 0};
    int            m_cap   [2] = '{-1, -1};
    int            m_stb   [2] = '{-10, -10};
    bit            m_first [2] = '{1, 1};
    bit            m_chg   [2] = '{0, 0};
    logic [DW-1:0] m_data  [2] = '{16'h0, 16'h0};
    int            m_ovr   [2] = '{0, 0};

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_since = 0;
            for (int i = 0; i < 2; i++) begin
                m_req[i]   = 1'b0;
                m_cap[i]   = -1;
                m_stb[i]   = -10;
                m_first[i] = 1'b1;
                m_chg[i]   = 1'b0;
                m_data[i]  = '0;
                m_ovr[i]   = 0;
            end
        end else begin
            bit tk;
            bit busy;
            logic [DW-1:0] nd;
            cyc++;
            tk = en && (m_since % P == P - 1);
            m_since = en ? m_since + 1 : 0;
            nd = rdat[DW-1:0];
            for (int i = 0; i < 2; i++) begin
                busy = m_req[i] || m_cap[i] >= 0 || m_stb[i] == cyc - 1;
                if (m_cap[i] == cyc) begin
                    m_chg[i]   = m_first[i] || (nd != m_data[i]);
                    m_first[i] = 1'b0;
                    m_data[i]  = nd;
                    m_cap[i]   = -1;
                    m_stb[i]   = cyc;
                end
                if (m_req[i] && !wr) begin
                    m_req[i] = 1'b0;
                    m_cap[i] = cyc + lat_of(i);
                end
                if (tk) begin
                    if (busy) m_ovr[i] = (m_ovr[i] < 255) ? m_ovr[i] + 1 : 255;
                    else m_req[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                bit ev;
                bit ec;
                ev = (m_stb[i] == cyc);
                ec = ev && m_chg[i];
                checks++;
                if (rdq[i] !== m_req[i] || adr[i] !== 2'b00 ||
                    sv[i] !== ev || sc[i] !== ec ||
                    sd[i] !== m_data[i] || ov[i] !== 8'(m_ovr[i])) begin
                    failures++;
                    $display("FAIL cmp dut%0d cyc=%0d actual rd=%b a=%0d v=%b c=%b d=%h o=%0d required rd=%b a=0 v=%b c=%b d=%h o=%0d",
                             i, cyc, rdq[i], adr[i], sv[i], sc[i], sd[i], ov[i],
                             m_req[i], ev, ec, m_data[i], m_ovr[i]);
                end
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        en    = 1'b0;
        wr    = 1'b0;
        rdat  = 32'h0000_00A5;
        step(3);
        reset  = 1'b0;
        chk_on = 1'b1;
        lit("rst_read", 32'(rdq[0]), 0);
        lit("rst_valid", 32'(sv[0]), 0);
        lit("rst_data", 32'(sd[0]), 0);
        lit("rst_ovr", 32'(ov[0]), 0);

        en = 1'b1;
        step(10);
        lit("t1_valid", 32'(sv[0]), 1);
        lit("t1_chg", 32'(sc[0]), 1);
        lit("t1_data", 32'(sd[0]), 32'hA5);
        step(8);
        lit("t1_valid2", 32'(sv[0]), 1);
        lit("t1_chg2", 32'(sc[0]), 0);
        step(2);
        rdat = 32'hFFFF_5A00;
        step(6);
        lit("t2_chg", 32'(sc[0]), 1);
        lit("t2_data", 32'(sd[0]), 32'h5A00);
        step(2);
        lit("t2_l3_data", 32'(sd[1]), 32'h5A00);
        lit("t2_l3_chg", 32'(sc[1]), 1);
        en = 1'b0;
        step(12);

        en = 1'b1;
        wr = 1'b1;
        step(8);
        lit("t3_read_start", 32'(rdq[0]), 1);
        step(3);
        lit("t3_read_held", 32'(rdq[0]), 1);
        wr = 1'b0;
        step(1);
        lit("t3_read_done", 32'(rdq[0]), 0);
        step(1);
        lit("t3_valid", 32'(sv[0]), 1);
        lit("t3_ovr", 32'(ov[0]), 0);
        en = 1'b0;
        step(12);

        en = 1'b1;
        wr = 1'b1;
        step(28);
        wr = 1'b0;
        en = 1'b0;
        lit("t4_ovr0", 32'(ov[0]), 2);
        lit("t4_ovr1", 32'(ov[1]), 2);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (sv[0]) n++;
        end
        lit("t4_one_valid", 32'(n), 1);

        en = 1'b1;
        wr = 1'b1;
        step(2450);
        lit("sat_ovr0", 32'(ov[0]), 255);
        lit("sat_ovr1", 32'(ov[1]), 255);
        wr = 1'b0;
        en = 1'b0;
        step(12);

        rdat = 32'h0000_1111;
        en = 1'b1;
        step(11);
        rdat = 32'h0000_2222;
        step(1);
        lit("t5_l3_data", 32'(sd[1]), 32'h2222);
        lit("t5_l3_valid", 32'(sv[1]), 1);
        lit("t5_l1_data", 32'(sd[0]), 32'h1111);
        en = 1'b0;
        step(12);

        en = 1'b1;
        step(10);
        lit("t6_pre_valid", 32'(sv[0]), 1);
        #2 reset = 1'b1;
        #1;
        lit("t6_l1_valid", 32'(sv[0]), 0);
        lit("t6_l1_data", 32'(sd[0]), 0);
        lit("t6_l3_read", 32'(rdq[1]), 0);
        lit("t6_l3_valid", 32'(sv[1]), 0);
        lit("t6_ovr", 32'(ov[1]), 0);
        step(2);
        reset = 1'b0;
        step(10);
        lit("t6_post_valid", 32'(sv[0]), 1);
        lit("t6_post_chg", 32'(sc[0]), 1);
        lit("t6_post_data", 32'(sd[0]), 32'h2222);
        en = 1'b0;
        step(12);

        en = 1'b1;
        wr = 1'b1;
        step(9);
        en = 1'b0;
        step(1);
        wr = 1'b0;
        step(2);
        lit("t7_valid", 32'(sv[0]), 1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (rdq[0] || rdq[1]) n++;
        end
        lit("t7_no_read", 32'(n), 0);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
